// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/load handshake, status and display lines of the 7-segment driver
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 14
);
    logic [VAL_W-1:0]    value;
    logic                load;
    logic [N_DIGITS-1:0] dp_mask;
    logic                busy;
    logic                ovf;
    logic [N_DIGITS-1:0] seg_sel;
    logic [7:0]          seg;

    modport master (output value, load, dp_mask, input busy, ovf, seg_sel, seg);
    modport slave  (input value, load, dp_mask, output busy, ovf, seg_sel, seg);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed 7-segment driver with sequential shift-add-3 BCD converter
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input logic clk,
    input logic rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int SCR_C = (VAL_W * 302 + 999) / 1000 + 1;
    localparam int SCR_N = SCR_C > N_DIGITS ? SCR_C : N_DIGITS + 1;
    localparam int PW    = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW    = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int CW    = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state;
    logic [VAL_W-1:0]    sh;
    logic [4*SCR_N-1:0]  scr, adj;
    logic [CW-1:0]       cnt;
    logic [4*N_DIGITS-1:0] disp;
    logic                busy, ovf;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx, nidx;
    logic [N_DIGITS-1:0] seg_sel;
    logic [7:0]          seg;
    logic [6:0]          glyph;

    assign bus.busy    = busy;
    assign bus.ovf     = ovf;
    assign bus.seg_sel = seg_sel;
    assign bus.seg     = seg;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: dec = 7'h40;
            4'd1: dec = 7'h79;
            4'd2: dec = 7'h24;
            4'd3: dec = 7'h30;
            4'd4: dec = 7'h19;
            4'd5: dec = 7'h12;
            4'd6: dec = 7'h02;
            4'd7: dec = 7'h78;
            4'd8: dec = 7'h00;
            4'd9: dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction

    always_comb begin
        adj = scr;
        for (int k = 0; k < SCR_N; k++)
            adj[4*k +: 4] = scr[4*k +: 4] >= 4'd5 ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
    end

    // IDLE with busy still set is the extra cycle that drops busy and ignores load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            sh    <= '0;
            scr   <= '0;
            cnt   <= '0;
            disp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (bus.load) begin
                        sh    <= bus.value;
                        scr   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr <= (adj << 1) | {{(4*SCR_N-1){1'b0}}, sh[VAL_W-1]};
                    sh  <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(VAL_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    ovf   <= |scr[4*SCR_N-1:4*N_DIGITS];
                    disp  <= |scr[4*SCR_N-1:4*N_DIGITS] ? {N_DIGITS{4'h9}} : scr[4*N_DIGITS-1:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nidx = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS:0] lz;
    always_comb begin
        lz = '0;
        lz[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--)
            lz[i] = lz[i+1] && disp[4*i +: 4] == 4'd0;
        glyph = (nidx != '0 && lz[nidx]) ? 7'h7F : dec(disp[4*int'(nidx) +: 4]);
    end
`else
    assign glyph = dec(disp[4*int'(nidx) +: 4]);
`endif

    // outputs change only at the slot wrap, so a commit never glitches the current slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            seg_sel <= '1;
            seg     <= 8'hFF;
        end else if (pre == PW'(REFRESH_DIV - 1)) begin
            pre     <= '0;
            idx     <= nidx;
            seg_sel <= ~(N_DIGITS'(1) << nidx);
            seg     <= {~bus.dp_mask[nidx], glyph};
        end else begin
            pre <= pre + 1'b1;
        end
    end
endmodule
